debug_trace_buffer: RTL and testbench

- Parametrised on-chip trace capture unit: the in-house successor to the vendor ICON/ILA/VIO debug wrapper around the CPU.
- Samples NUM_CH probe words every clock into a circular buffer. Arms on command and triggers on a masked compare, a transition, or a force input.
- Captures a programmable number of post-trigger samples, then freezes the buffer for oldest-first readout.
- Sits beside CPU in top; probes pc, x31, x3 and any other register taps.

---
 rtl/debug_trace_buffer_if.sv | 40 ++++
 rtl/debug_trace_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_debug_trace_buffer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/debug_trace_buffer_if.sv
// Signal bundle between the trace buffer and its host: probe feed, trigger
// configuration, capture control and readout.
interface debug_trace_buffer_if #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*DATA_W-1:0] probe_i;
  logic                     arm_i;
  logic                     abort_i;
  logic                     trig_force_i;
  logic [CH_W-1:0]          trig_ch_i;
  logic [1:0]               trig_mode_i;
  logic [DATA_W-1:0]        trig_value_i;
  logic [DATA_W-1:0]        trig_mask_i;
  logic [ADDR_W-1:0]        post_trig_i;
  logic                     rd_en_i;
  logic [ADDR_W-1:0]        rd_idx_i;
  logic [NUM_CH*DATA_W-1:0] rd_data_o;
  logic                     rd_valid_o;
  logic [1:0]               state_o;
  logic                     done_o;
  logic [ADDR_W:0]          valid_cnt_o;
  logic [ADDR_W-1:0]        trig_idx_o;

  modport master (
    output probe_i, arm_i, abort_i, trig_force_i, trig_ch_i, trig_mode_i,
           trig_value_i, trig_mask_i, post_trig_i, rd_en_i, rd_idx_i,
    input  rd_data_o, rd_valid_o, state_o, done_o, valid_cnt_o, trig_idx_o
  );

  modport slave (
    input  probe_i, arm_i, abort_i, trig_force_i, trig_ch_i, trig_mode_i,
           trig_value_i, trig_mask_i, post_trig_i, rd_en_i, rd_idx_i,
    output rd_data_o, rd_valid_o, state_o, done_o, valid_cnt_o, trig_idx_o
  );
endinterface

// File: rtl/debug_trace_buffer.sv
// On-chip trace capture: circular sample buffer with masked/transition/force
// trigger, post-trigger count and frozen oldest-first readout.
module debug_trace_buffer #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic                 clk_i,
  input logic                 reset_i,
  debug_trace_buffer_if.slave bus
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FILL_W = ADDR_W + 1;
  localparam int WORD_W = NUM_CH * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    M_EQ    = 2'b00,
    M_NE    = 2'b01,
    M_TRANS = 2'b10,
    M_NEVER = 2'b11
  } trig_mode_e;

  logic [WORD_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [FILL_W-1:0] valid_cnt_q, valid_cnt_d;
  logic [ADDR_W-1:0] trig_idx_q, trig_idx_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  trig_mode_e        mode_q, mode_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0] post_q, post_d;
  logic [WORD_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic              wr_en;
  logic              enter_done;
  logic              hit;
  logic              rd_fire;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] sample;

  always_comb begin
    sample = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) sample = bus.probe_i[k*DATA_W +: DATA_W];
    end

    unique case (mode_q)
      M_EQ:    hit = (sample & mask_q) == (value_q & mask_q);
      M_NE:    hit = (sample & mask_q) != (value_q & mask_q);
      M_TRANS: hit = prev_vld_q && ((sample & mask_q) != (prev_q & mask_q));
      default: hit = 1'b0;
    endcase
    hit = hit | bus.trig_force_i;
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    remain_d    = remain_q;
    trig_ptr_d  = trig_ptr_q;
    start_d     = start_q;
    valid_cnt_d = valid_cnt_q;
    trig_idx_d  = trig_idx_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    ch_d        = ch_q;
    mode_d      = mode_q;
    value_d     = value_q;
    mask_d      = mask_q;
    post_d      = post_q;
    wr_en       = 1'b0;
    enter_done  = 1'b0;

    if (bus.abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.arm_i) begin
            state_d     = S_ARMED;
            wr_ptr_d    = '0;
            fill_d      = '0;
            valid_cnt_d = '0;
            prev_vld_d  = 1'b0;
            ch_d        = bus.trig_ch_i;
            mode_d      = trig_mode_e'(bus.trig_mode_i);
            value_d     = bus.trig_value_i;
            mask_d      = bus.trig_mask_i;
            post_d      = bus.post_trig_i;
          end
        end
        S_ARMED, S_POST: begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          fill_d   = (fill_q == FILL_W'(DEPTH)) ? fill_q : fill_q + FILL_W'(1);
          if (state_q == S_ARMED) begin
            prev_d     = sample;
            prev_vld_d = 1'b1;
            if (hit) begin
              trig_ptr_d = wr_ptr_q;
              if (post_q == '0) begin
                enter_done = 1'b1;
              end else begin
                state_d  = S_POST;
                remain_d = post_q;
              end
            end
          end else begin
            remain_d = remain_q - ADDR_W'(1);
            if (remain_q == ADDR_W'(1)) enter_done = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Once the buffer has filled, the oldest sample sits at the next write slot.
    if (enter_done) begin
      state_d     = S_DONE;
      valid_cnt_d = fill_d;
      start_d     = fill_d[ADDR_W] ? wr_ptr_d : '0;
      trig_idx_d  = trig_ptr_d - start_d;
    end
  end

  assign rd_fire = (state_q == S_DONE) && bus.rd_en_i;
  assign rd_addr = start_q + bus.rd_idx_i;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      remain_q    <= '0;
      trig_ptr_q  <= '0;
      start_q     <= '0;
      valid_cnt_q <= '0;
      trig_idx_q  <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      ch_q        <= '0;
      mode_q      <= M_NEVER;
      value_q     <= '0;
      mask_q      <= '0;
      post_q      <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      remain_q    <= remain_d;
      trig_ptr_q  <= trig_ptr_d;
      start_q     <= start_d;
      valid_cnt_q <= valid_cnt_d;
      trig_idx_q  <= trig_idx_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      ch_q        <= ch_d;
      mode_q      <= mode_d;
      value_q     <= value_d;
      mask_q      <= mask_d;
      post_q      <= post_d;
      rd_valid_q  <= rd_fire;
    end
  end

  // NOTE: the sample RAM is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= bus.probe_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i)     rd_data_q <= '0;
    else if (rd_fire) rd_data_q <= mem[rd_addr];
  end

  assign bus.rd_data_o   = rd_data_q;
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.state_o     = state_q;
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.valid_cnt_o = valid_cnt_q;
  assign bus.trig_idx_o  = trig_idx_q;
endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed bench for debug_trace_buffer at DEPTH=16: trigger modes, wrap,
// force, abort, reset, readout latency and config shadowing.
module tb_debug_trace_buffer;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  debug_trace_buffer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  debug_trace_buffer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] word(input int c0, input int c1);
    logic [31:0] c2;
    c2 = 32'hA5A5_0000 | 32'(c0);
    return {c2, 32'(c1), 32'(c0)};
  endfunction

  task automatic drive(input int c0, input int c1);
    bus.probe_i = word(c0, c1);
  endtask

  task automatic cfg(input int ch, input logic [1:0] mode, input logic [31:0] val,
                     input logic [31:0] mask, input int post);
    bus.trig_ch_i    = 2'(ch);
    bus.trig_mode_i  = mode;
    bus.trig_value_i = val;
    bus.trig_mask_i  = mask;
    bus.post_trig_i  = 4'(post);
  endtask

  task automatic arm();
    bus.probe_i = {3{32'hDEAD_BEEF}};
    bus.arm_i   = 1'b1;
    step();
    bus.arm_i   = 1'b0;
  endtask

  task automatic rd(input string tag, input int idx, input logic [95:0] exp);
    bus.rd_en_i  = 1'b1;
    bus.rd_idx_i = 4'(idx);
    step();
    bus.rd_en_i  = 1'b0;
    check({tag, "_valid"}, 96'(bus.rd_valid_o), 96'd1);
    check({tag, "_data"}, bus.rd_data_o, exp);
  endtask

  task automatic done_chk(input string tag, input int vcnt, input int tidx);
    check({tag, "_state"}, 96'(bus.state_o), 96'd3);
    check({tag, "_done"}, 96'(bus.done_o), 96'd1);
    check({tag, "_vcnt"}, 96'(bus.valid_cnt_o), 96'(vcnt));
    check({tag, "_tidx"}, 96'(bus.trig_idx_o), 96'(tidx));
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.probe_i      = '0;
    bus.arm_i        = 1'b0;
    bus.abort_i      = 1'b0;
    bus.trig_force_i = 1'b0;
    bus.rd_en_i      = 1'b0;
    bus.rd_idx_i     = '0;
    cfg(0, 2'b11, 0, 0, 0);
    step();
    step();
    reset_n = 1'b1;
    check("rst_state", 96'(bus.state_o), 96'd0);
    check("rst_done", 96'(bus.done_o), 96'd0);
    check("rst_vcnt", 96'(bus.valid_cnt_o), 96'd0);
    check("rst_tidx", 96'(bus.trig_idx_o), 96'd0);
    check("rst_rvalid", 96'(bus.rd_valid_o), 96'd0);
    check("rst_rdata", bus.rd_data_o, 96'd0);

    // Equal trigger on ch0==5, post 3; config and rd_en wiggled mid-capture.
    cfg(0, 2'b00, 5, 32'hFFFF_FFFF, 3);
    arm();
    check("t1_armed", 96'(bus.state_o), 96'd1);
    cfg(1, 2'b11, 2, 32'h0, 0);
    bus.rd_en_i = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      drive(k, k + 'h100);
      step();
      if (k == 1) check("t1_rd_in_armed", 96'(bus.rd_valid_o), 96'd0);
      if (k == 4) check("t1_still_armed", 96'(bus.state_o), 96'd1);
      if (k == 5) check("t1_post", 96'(bus.state_o), 96'd2);
    end
    bus.rd_en_i = 1'b0;
    done_chk("t1", 9, 5);
    for (int i = 0; i <= 8; i++) rd("t1_rd", i, word(i, i + 'h100));
    step();
    check("t1_rvalid_drop", 96'(bus.rd_valid_o), 96'd0);
    check("t1_rdata_hold", bus.rd_data_o, word(8, 8 + 'h100));

    // Wrap-around: trigger at 40, post 4.
    cfg(0, 2'b00, 40, 32'hFFFF_FFFF, 4);
    arm();
    for (int k = 0; k <= 44; k++) begin
      drive(k, k + 'h100);
      step();
    end
    done_chk("t2", 16, 11);
    rd("t2_oldest", 0, word(29, 29 + 'h100));
    rd("t2_trig", 11, word(40, 40 + 'h100));
    rd("t2_newest", 15, word(44, 44 + 'h100));

    // Transition on ch1 low nibble: 0x30 then 0x31 from sample 7.
    cfg(1, 2'b10, 0, 32'h0000_000F, 2);
    arm();
    for (int k = 0; k <= 9; k++) begin
      drive(k, (k < 7) ? 'h30 : 'h31);
      step();
      if (k == 0) check("t3_no_first_fire", 96'(bus.state_o), 96'd1);
      if (k == 7) check("t3_fire", 96'(bus.state_o), 96'd2);
    end
    done_chk("t3", 10, 7);
    rd("t3_trig", 7, word(7, 'h31));

    // Mask 0xF0 hides the change; force fires instead.
    cfg(1, 2'b10, 0, 32'h0000_00F0, 0);
    arm();
    for (int k = 0; k <= 11; k++) begin
      drive(k, (k < 7) ? 'h30 : 'h31);
      step();
    end
    check("t3b_no_trig", 96'(bus.state_o), 96'd1);
    drive(12, 'h31);
    bus.trig_force_i = 1'b1;
    step();
    bus.trig_force_i = 1'b0;
    done_chk("t3b", 13, 12);

    // Mode never, post 0, force on sample 2.
    cfg(0, 2'b11, 0, 32'hFFFF_FFFF, 0);
    arm();
    for (int k = 0; k <= 1; k++) begin
      drive(k, k + 'h100);
      step();
    end
    check("t4_armed", 96'(bus.state_o), 96'd1);
    drive(2, 2 + 'h100);
    bus.trig_force_i = 1'b1;
    step();
    bus.trig_force_i = 1'b0;
    done_chk("t4", 3, 2);
    rd("t4_rd1", 1, word(1, 1 + 'h100));

    // arm_i during POST is ignored.
    cfg(0, 2'b00, 3, 32'hFFFF_FFFF, 4);
    arm();
    for (int k = 0; k <= 7; k++) begin
      drive(k, k + 'h100);
      bus.arm_i = (k == 4);
      step();
      if (k == 4) check("t5_arm_in_post", 96'(bus.state_o), 96'd2);
    end
    bus.arm_i = 1'b0;
    done_chk("t5", 8, 3);

    // Abort in POST.
    cfg(0, 2'b00, 2, 32'hFFFF_FFFF, 5);
    arm();
    for (int k = 0; k <= 3; k++) begin
      drive(k, k + 'h100);
      step();
    end
    check("t6_post", 96'(bus.state_o), 96'd2);
    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    check("t6_abort_idle", 96'(bus.state_o), 96'd0);
    for (int k = 0; k < 3; k++) step();
    check("t6_no_done", 96'(bus.done_o), 96'd0);
    check("t6_stay_idle", 96'(bus.state_o), 96'd0);

    // Arm and abort together: abort wins.
    bus.arm_i   = 1'b1;
    bus.abort_i = 1'b1;
    step();
    bus.arm_i   = 1'b0;
    bus.abort_i = 1'b0;
    check("t7_arm_abort", 96'(bus.state_o), 96'd0);

    // Reset during ARMED clears everything visible.
    cfg(0, 2'b11, 0, 32'hFFFF_FFFF, 0);
    arm();
    for (int k = 0; k <= 2; k++) begin
      drive(k, k + 'h100);
      step();
    end
    check("t8_armed", 96'(bus.state_o), 96'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("t8_state", 96'(bus.state_o), 96'd0);
    check("t8_done", 96'(bus.done_o), 96'd0);
    check("t8_vcnt", 96'(bus.valid_cnt_o), 96'd0);
    check("t8_tidx", 96'(bus.trig_idx_o), 96'd0);
    check("t8_rvalid", 96'(bus.rd_valid_o), 96'd0);
    check("t8_rdata", bus.rd_data_o, 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
